// File: rtl/glitc_align_pkg.sv
// rtl/glitc_align_pkg.sv - shared FSM encoding, default pattern and lane indexing for the RITC aligner
package glitc_align_pkg;

    localparam logic [3:0] PATTERN_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } align_state_t;

    // Bit position of sample k of lane i inside one channel word
    function automatic int lane_bit(input int k, input int i, input int nbits);
        return k * nbits + i;
    endfunction

endpackage

// File: rtl/glitc_lane_match.sv
// rtl/glitc_lane_match.sv - registered all-lanes-show-pattern detector for one channel word
module glitc_lane_match
    import glitc_align_pkg::*;
#(
    parameter int               NBITS   = 12,
    parameter int               NSAMP   = 4,
    parameter logic [NSAMP-1:0] PATTERN = PATTERN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NBITS*NSAMP-1:0] word_i,
    output logic                   match_o
);

    logic match_d;
    logic match_q;

    // Every lane must present the full training nibble; any single wrong bit clears the match
    always_comb begin
        match_d = 1'b1;
        for (int i = 0; i < NBITS; i++) begin
            for (int k = 0; k < NSAMP; k++) begin
                if (word_i[lane_bit(k, i, NBITS)] != PATTERN[k]) begin
                    match_d = 1'b0;
                end
            end
        end
    end

    // One register stage so the controller sees a clean per-word decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match_o = match_q;

endmodule

// File: rtl/glitc_align_ctrl.sv
// rtl/glitc_align_ctrl.sv - bitslip word-alignment sequencer for the A/B/C RITC deserialisers
module glitc_align_ctrl
    import glitc_align_pkg::*;
#(
    parameter int               NCH        = 3,
    parameter int               NBITS      = 12,
    parameter int               NSAMP      = 4,
    parameter logic [NSAMP-1:0] PATTERN    = PATTERN_DEFAULT,
    parameter int               SETTLE_CYC = 16,
    parameter int               CHECK_LEN  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [NCH*NBITS*NSAMP-1:0]   data_i,
    output logic                         train_o,
    output logic                         enable_o,
    output logic [NCH-1:0]               bitslip_o,
    output logic [NCH-1:0]               aligned_o,
    output logic [NCH-1:0]               fail_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int WORD_W = NBITS * NSAMP;
    localparam int MW     = $clog2(CHECK_LEN + 1);
    localparam int SW     = $clog2(SETTLE_CYC + 1);
    localparam int LW     = $clog2(NSAMP + 1);
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;

    align_state_t   state_q, state_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [LW-1:0]  slip_cnt_q, slip_cnt_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic [MW-1:0]  match_cnt_q, match_cnt_d;
    logic [NCH-1:0] aligned_q, aligned_d;
    logic [NCH-1:0] fail_q, fail_d;
    logic           enable_q, enable_d;
    logic [NCH-1:0] match_r;

    for (genvar c = 0; c < NCH; c++) begin : g_match
        glitc_lane_match #(
            .NBITS   (NBITS),
            .NSAMP   (NSAMP),
            .PATTERN (PATTERN)
        ) u_match (
            .clk     (clk),
            .rst     (rst),
            .word_i  (data_i[c*WORD_W +: WORD_W]),
            .match_o (match_r[c])
        );
    end

    // Sequencer: settle, check, slip until aligned or out of phases, then move to the next channel
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        slip_cnt_d  = slip_cnt_q;
        settle_d    = settle_q;
        match_cnt_d = match_cnt_q;
        aligned_d   = aligned_q;
        fail_d      = fail_q;
        enable_d    = enable_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    aligned_d   = '0;
                    fail_d      = '0;
                    ch_d        = '0;
                    slip_cnt_d  = '0;
                    settle_d    = '0;
                    match_cnt_d = '0;
                    enable_d    = 1'b0;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                    settle_d    = '0;
                    match_cnt_d = '0;
                    state_d     = ST_CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (match_r[ch_q]) begin
                    if (match_cnt_q == MW'(CHECK_LEN - 1)) begin
                        match_cnt_d     = MW'(CHECK_LEN);
                        aligned_d[ch_q] = 1'b1;
                        state_d         = ST_NEXT;
                    end else begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end else begin
                    match_cnt_d = '0;
                    if (slip_cnt_q == LW'(NSAMP)) begin
                        fail_d[ch_q] = 1'b1;
                        state_d      = ST_NEXT;
                    end else begin
                        state_d = ST_SLIP;
                    end
                end
            end
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 1'b1;
                settle_d   = '0;
                state_d    = ST_SETTLE;
            end
            ST_NEXT: begin
                if (ch_q == CW'(NCH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d       = ch_q + 1'b1;
                    slip_cnt_d = '0;
                    settle_d   = '0;
                    state_d    = ST_SETTLE;
                end
            end
            ST_DONE: begin
                enable_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and sticky status; reset clears everything at once, mid-sequence included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            slip_cnt_q  <= '0;
            settle_q    <= '0;
            match_cnt_q <= '0;
            aligned_q   <= '0;
            fail_q      <= '0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            slip_cnt_q  <= slip_cnt_d;
            settle_q    <= settle_d;
            match_cnt_q <= match_cnt_d;
            aligned_q   <= aligned_d;
            fail_q      <= fail_d;
            enable_q    <= enable_d;
        end
    end

    // Slip pulse decoded from the state so a reset truncates it immediately
    always_comb begin
        bitslip_o = '0;
        if (state_q == ST_SLIP) begin
            bitslip_o[ch_q] = 1'b1;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign train_o   = busy_o;
    assign done_o    = (state_q == ST_DONE);
    assign enable_o  = enable_q | (state_q == ST_DONE);
    assign aligned_o = aligned_q;
    assign fail_o    = fail_q;

endmodule

// File: tb/tb_glitc_align_ctrl.sv
// tb/tb_glitc_align_ctrl.sv - self-checking bench for glitc_align_ctrl
`timescale 1ns/1ps
module tb_glitc_align_ctrl;

    localparam int         NCH   = 3;
    localparam int         NBITS = 12;
    localparam int         NSAMP = 4;
    localparam int         W     = NBITS * NSAMP;
    localparam int         S     = 16;
    localparam int         C     = 64;
    localparam logic [3:0] PAT   = 4'b0011;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             start_i = 1'b0;
    logic [NCH*W-1:0] data_i  = '0;
    logic             train_o, enable_o, busy_o, done_o;
    logic [NCH-1:0]   bitslip_o, aligned_o, fail_o;

    int vectors     = 0;
    int miscompares = 0;

    int         base_phase   [NCH];
    int         eff_base     [NCH];
    int         eff          [NCH];
    int         seen         [NCH];
    int         snap         [NCH];
    bit         force_en     [NCH];
    logic [3:0] force_nib    [NCH];
    int         stuck_lane   [NCH];
    bit         glitch       [NCH];
    bit         slip_ignored [NCH];
    int         p1           [NCH];
    int         p2           [NCH];

    logic [NCH-1:0] mr;
    bit             m_busy, m_enable, m_done, aborted;
    logic [NCH-1:0] m_slip, m_aligned, m_fail;

    always #5 clk = ~clk;

    glitc_align_ctrl #(
        .NCH        (NCH),
        .NBITS      (NBITS),
        .NSAMP      (NSAMP),
        .PATTERN    (PAT),
        .SETTLE_CYC (S),
        .CHECK_LEN  (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .data_i    (data_i),
        .train_o   (train_o),
        .enable_o  (enable_o),
        .bitslip_o (bitslip_o),
        .aligned_o (aligned_o),
        .fail_o    (fail_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    function automatic logic [3:0] lane_nib(input int c);
        logic [7:0] two;
        int p;
        if (force_en[c]) return force_nib[c];
        if (glitch[c]) return 4'b0000;
        p = (base_phase[c] + eff[c] - eff_base[c]) % 4;
        two = {PAT, PAT} << p;
        return two[7:4];
    endfunction

    function automatic logic [NCH*W-1:0] build_all();
        logic [NCH*W-1:0] d;
        logic [3:0] nib;
        d = '0;
        for (int c = 0; c < NCH; c++) begin
            nib = lane_nib(c);
            for (int i = 0; i < NBITS; i++)
                for (int k = 0; k < NSAMP; k++)
                    d[c*W + k*NBITS + i] = (stuck_lane[c] == i) ? 1'b0 : nib[k];
        end
        return d;
    endfunction

    function automatic logic [NCH-1:0] model_match(input logic [NCH*W-1:0] d);
        logic [NCH-1:0] r;
        logic [3:0] lane;
        for (int c = 0; c < NCH; c++) begin
            r[c] = 1'b1;
            for (int i = 0; i < NBITS; i++) begin
                lane = {d[c*W+36+i], d[c*W+24+i], d[c*W+12+i], d[c*W+i]};
                if (lane != PAT) r[c] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        aborted = rst;
        if (rst) begin
            mr = '0;
            m_busy = 0; m_enable = 0; m_done = 0;
            m_slip = '0; m_aligned = '0; m_fail = '0;
        end else begin
            mr = model_match(data_i);
        end
    endtask

    task automatic run_seq();
        bit m;
        int cnt, slips;
        m_busy = 1; m_enable = 0; m_done = 0;
        m_slip = '0; m_aligned = '0; m_fail = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            slips = 0;
            forever begin
                repeat (S) begin
                    tick();
                    if (aborted) return;
                end
                cnt = 0;
                forever begin
                    m = mr[ch];
                    tick();
                    if (aborted) return;
                    if (!m) break;
                    cnt++;
                    if (cnt == C) begin
                        m_aligned[ch] = 1'b1;
                        break;
                    end
                end
                if (cnt == C) break;
                if (slips == NSAMP) begin
                    m_fail[ch] = 1'b1;
                    break;
                end
                m_slip = '0;
                m_slip[ch] = 1'b1;
                slips++;
                tick();
                if (aborted) return;
                m_slip = '0;
            end
            tick();
            if (aborted) return;
        end
        m_done = 1; m_enable = 1;
        tick();
        if (aborted) return;
        m_done = 0; m_busy = 0;
    endtask

    task automatic model_loop();
        m_busy = 0; m_enable = 0; m_done = 0;
        m_slip = '0; m_aligned = '0; m_fail = '0;
        forever begin
            tick();
            if (!aborted && start_i) run_seq();
        end
    endtask

    task automatic compare_loop();
        logic [12:0] a, e;
        forever begin
            @(negedge clk);
            a = {train_o, enable_o, bitslip_o, aligned_o, fail_o, busy_o, done_o};
            if (rst) e = '0;
            else     e = {m_busy, m_enable, m_slip, m_aligned, m_fail, m_busy, m_done};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t {train,enable,bitslip,aligned,fail,busy,done}=%b expected %b",
                         $time, a, e);
            end
        end
    endtask

    task automatic emulator_loop();
        for (int c = 0; c < NCH; c++) begin
            eff[c] = 0;
            seen[c] = 0;
        end
        data_i = build_all();
        forever begin
            @(posedge clk);
            #3;
            for (int c = 0; c < NCH; c++) begin
                if (bitslip_o[c]) begin
                    seen[c]++;
                    if (!slip_ignored[c]) eff[c]++;
                end
            end
            data_i = build_all();
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic clean();
        for (int c = 0; c < NCH; c++) begin
            base_phase[c]   = 0;
            eff_base[c]     = eff[c];
            force_en[c]     = 0;
            force_nib[c]    = PAT;
            stuck_lane[c]   = -1;
            glitch[c]       = 0;
            slip_ignored[c] = 0;
            snap[c]         = seen[c];
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic run_to_done(input int n0, input int limit, output int done_at, output int al0_at);
        int n;
        n = n0; done_at = -1; al0_at = -1;
        for (int c = 0; c < NCH; c++) begin
            p1[c] = -1;
            p2[c] = -1;
        end
        while (n < n0 + limit) begin
            for (int c = 0; c < NCH; c++) begin
                if (bitslip_o[c]) begin
                    if (p1[c] < 0) p1[c] = n;
                    else if (p2[c] < 0) p2[c] = n;
                end
            end
            if (al0_at < 0 && aligned_o[0]) al0_at = n;
            if (done_o) begin
                done_at = n;
                break;
            end
            step();
            n++;
        end
        vectors++;
        if (done_at < 0) begin
            miscompares++;
            $display("FAIL done_timeout: done_o not seen within %0d cycles, required one done pulse", limit);
        end
    endtask

    initial begin
        int d, a0, n;
        bit found;
        for (int c = 0; c < NCH; c++) begin
            eff[c] = 0;
            seen[c] = 0;
        end
        clean();
        fork
            model_loop();
            compare_loop();
            emulator_loop();
        join_none

        repeat (3) step();
        lit("reset_outputs", int'({train_o, enable_o, bitslip_o, aligned_o, fail_o, busy_o, done_o}), 0);
        rst = 1'b0;
        step();
        lit("idle_enable", int'(enable_o), 0);

        // 1: everything already aligned
        clean();
        pulse_start();
        lit("t1_enable_falls", int'(enable_o), 0);
        lit("t1_busy", int'(busy_o), 1);
        run_to_done(1, 2000, d, a0);
        lit("t1_aligned_latency", a0, 1 + S + C);
        lit("t1_done_latency", d, 3 * (S + C) + 4);
        lit("t1_aligned", int'(aligned_o), 7);
        lit("t1_enable_in_done", int'(enable_o), 1);
        lit("t1_slips", seen[0] + seen[1] + seen[2] - snap[0] - snap[1] - snap[2], 0);
        step();
        lit("t1_done_one_cycle", int'(done_o), 0);
        lit("t1_enable_after", int'(enable_o), 1);

        // 2: channel B rotated by two samples
        clean();
        base_phase[1] = 2;
        step();
        pulse_start();
        run_to_done(1, 2000, d, a0);
        lit("t2_b_slips", seen[1] - snap[1], 2);
        lit("t2_a_slips", seen[0] - snap[0], 0);
        lit("t2_c_slips", seen[2] - snap[2], 0);
        lit("t2_first_slip_cycle", p1[1], 2 * S + C + 3);
        lit("t2_slip_spacing", p2[1] - p1[1], S + 2);
        lit("t2_aligned", int'(aligned_o), 7);

        // 3: channel C never matches, then a start in the DONE cycle is ignored
        clean();
        force_en[2] = 1;
        force_nib[2] = 4'b0101;
        step();
        pulse_start();
        run_to_done(1, 2000, d, a0);
        lit("t3_c_slips", seen[2] - snap[2], 4);
        lit("t3_fail", int'(fail_o), 4);
        lit("t3_aligned", int'(aligned_o), 3);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        lit("t3_start_in_done_ignored", int'(busy_o), 0);
        step();
        lit("t3_still_idle", int'(busy_o), 0);
        lit("t3_status_kept", int'(fail_o), 4);

        // 4: channel A glitches after 40 good words
        clean();
        slip_ignored[0] = 1;
        step();
        pulse_start();
        repeat (S + 39) step();
        glitch[0] = 1;
        step();
        glitch[0] = 0;
        run_to_done(S + 41, 2000, d, a0);
        lit("t4_a_slips", seen[0] - snap[0], 1);
        lit("t4_aligned_latency", a0, 2 * S + C + 43);
        lit("t4_aligned", int'(aligned_o), 7);

        // 5: reset during B's slip, second start while busy ignored, rerun from A
        clean();
        base_phase[1] = 1;
        step();
        pulse_start();
        n = 1;
        found = 0;
        while (n < 400 && !found) begin
            if (bitslip_o[1]) begin
                found = 1;
            end else begin
                start_i = (n == 10);
                step();
                n++;
            end
        end
        start_i = 1'b0;
        lit("t5_slip_seen", int'(found), 1);
        lit("t5_slip_cycle", n, 2 * S + C + 3);
        rst = 1'b1;
        #1;
        lit("t5_rst_bitslip", int'(bitslip_o), 0);
        lit("t5_rst_busy", int'(busy_o), 0);
        lit("t5_rst_aligned", int'(aligned_o), 0);
        step();
        step();
        rst = 1'b0;
        step();
        for (int c = 0; c < NCH; c++) snap[c] = seen[c];
        pulse_start();
        run_to_done(1, 2000, d, a0);
        lit("t5_restart_from_a", a0, 1 + S + C);
        lit("t5_b_slips", seen[1] - snap[1], 3);
        lit("t5_aligned", int'(aligned_o), 7);

        // 6: lane 7 of channel A stuck low
        clean();
        stuck_lane[0] = 7;
        step();
        pulse_start();
        run_to_done(1, 2000, d, a0);
        lit("t6_a_slips", seen[0] - snap[0], 4);
        lit("t6_fail", int'(fail_o), 1);
        lit("t6_aligned", int'(aligned_o), 6);
        step();
        lit("t6_enable_after", int'(enable_o), 1);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
